// File: rtl/mem_stage_pipe.sv
// mem_stage_pipe: MEM pipeline stage between EX and WB.
// Waits for the data-SRAM response of an in-flight load/store, buffers it while WB stalls,
// extracts and extends load data, and drops stale responses after a flush.
// Optional feature macro: MEM_STAGE_FWD_EN (adds the ms_fwd_* forwarding outputs).
module mem_stage_pipe #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned PC_W      = 32,
    parameter int unsigned RF_ADDR_W = 5,
    parameter int unsigned MAX_OUTST = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        es2ms_valid,
    output logic                        ms_allowin,
    input  logic [PC_W-1:0]             es_pc,
    input  logic                        es_mem_req,
    input  logic [2:0]                  es_ld_op,
    input  logic                        es_res_from_mem,
    input  logic                        es_rf_we,
    input  logic [RF_ADDR_W-1:0]        es_rf_waddr,
    input  logic [DATA_W-1:0]           es_alu_result,
    input  logic                        data_sram_data_ok,
    input  logic [DATA_W-1:0]           data_sram_rdata,
    input  logic                        ms_flush,
    output logic                        ms_discard_busy,
    output logic                        ms2ws_valid,
    input  logic                        ws_allowin,
    output logic [PC_W-1:0]             ms_pc,
`ifdef MEM_STAGE_FWD_EN
    output logic                        ms_fwd_we,
    output logic [RF_ADDR_W-1:0]        ms_fwd_waddr,
    output logic [DATA_W-1:0]           ms_fwd_wdata,
    output logic                        ms_fwd_stall,
`endif
    output logic [RF_ADDR_W+DATA_W:0]   ms_rf_zip
);

    localparam int unsigned CNT_W  = (MAX_OUTST < 1) ? 1 : $clog2(MAX_OUTST + 1);
    localparam int unsigned SUM_W  = CNT_W + 2;
    localparam int unsigned LANE_W = $clog2(DATA_W / 8);

    typedef enum logic [2:0] {
        LdW  = 3'd0,
        LdB  = 3'd1,
        LdBu = 3'd2,
        LdH  = 3'd3,
        LdHu = 3'd4,
        LdWu = 3'd5,
        LdD  = 3'd6
    } ld_op_e;

    logic                 r_valid;
    logic [PC_W-1:0]      r_pc;
    logic                 r_mem_req;
    logic [2:0]           r_ld_op;
    logic                 r_res_from_mem;
    logic                 r_rf_we;
    logic [RF_ADDR_W-1:0] r_rf_waddr;
    logic [DATA_W-1:0]    r_alu_result;
    logic [DATA_W-1:0]    r_rdata_buf;
    logic                 r_got;
    logic [CNT_W-1:0]     r_discard_cnt;

    logic                 w_deliver;
    logic                 w_drop;
    logic                 w_ready_go;
    logic                 w_capture;
    logic                 w_waiting;
    logic                 w_inc_wait;
    logic                 w_inc_ex;
    logic [SUM_W-1:0]     w_cnt_sum;
    logic [DATA_W-1:0]    w_ld_src;
    logic [LANE_W-1:0]    w_lane;
    logic                 w_word_hi;
    logic [DATA_W-1:0]    w_shift_b;
    logic [DATA_W-1:0]    w_shift_h;
    logic [DATA_W-1:0]    w_shift_w;
    logic [DATA_W-1:0]    w_ld_data;
    logic [DATA_W-1:0]    w_rf_wdata;

    // Handshake and discard-counter arithmetic
    always_comb begin
        w_deliver  = data_sram_data_ok & (r_discard_cnt == '0);
        w_drop     = data_sram_data_ok & (r_discard_cnt != '0);
        w_ready_go = ~r_mem_req | r_got | w_deliver;
        w_waiting  = r_valid & r_mem_req & ~r_got;
        ms_allowin = ~r_valid | (w_ready_go & ws_allowin);
        ms2ws_valid = r_valid & w_ready_go & ~ms_flush;
        w_capture  = es2ms_valid & ms_allowin & ~ms_flush;
        // On flush, the killed MEM request and a request just issued by EX still owe responses
        w_inc_wait = ms_flush & w_waiting & ~data_sram_data_ok;
        w_inc_ex   = ms_flush & es2ms_valid & es_mem_req;
        w_cnt_sum  = SUM_W'(r_discard_cnt) + SUM_W'(w_inc_wait) + SUM_W'(w_inc_ex)
                   - SUM_W'(w_drop);
        ms_discard_busy = (r_discard_cnt != '0);
    end

    // Load data select, lane extraction and sign/zero extension
    always_comb begin
        w_ld_src  = r_got ? r_rdata_buf : data_sram_rdata;
        w_lane    = r_alu_result[LANE_W-1:0];
        w_word_hi = (DATA_W == 64) ? r_alu_result[2] : 1'b0;
        w_shift_b = w_ld_src >> {w_lane, 3'b000};
        w_shift_h = w_ld_src >> {w_lane[LANE_W-1:1], 4'b0000};
        w_shift_w = w_ld_src >> {w_word_hi, 5'b00000};
        w_ld_data = w_ld_src;
        case (ld_op_e'(r_ld_op))
            LdW:     w_ld_data = DATA_W'($signed(w_shift_w[31:0]));
            LdB:     w_ld_data = DATA_W'($signed(w_shift_b[7:0]));
            LdBu:    w_ld_data = DATA_W'(w_shift_b[7:0]);
            LdH:     w_ld_data = DATA_W'($signed(w_shift_h[15:0]));
            LdHu:    w_ld_data = DATA_W'(w_shift_h[15:0]);
            LdWu:    w_ld_data = DATA_W'(w_shift_w[31:0]);
            LdD:     w_ld_data = w_ld_src;
            default: w_ld_data = w_ld_src;
        endcase
        w_rf_wdata = r_res_from_mem ? w_ld_data : r_alu_result;
    end

    // Writeback bundle and PC towards WB
    always_comb begin
        ms_pc     = r_pc;
        ms_rf_zip = {r_rf_we & r_valid, r_rf_waddr, w_rf_wdata};
    end

`ifdef MEM_STAGE_FWD_EN
    // Bypass towards EX/ID; stall while a load result is still outstanding
    always_comb begin
        ms_fwd_we    = r_valid & r_rf_we & (r_rf_waddr != '0);
        ms_fwd_waddr = r_rf_waddr;
        ms_fwd_wdata = w_rf_wdata;
        ms_fwd_stall = ms_fwd_we & r_res_from_mem & ~w_ready_go;
    end
`endif

    // Pipeline valid and EX field capture
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid        <= 1'b0;
            r_pc           <= '0;
            r_mem_req      <= 1'b0;
            r_ld_op        <= '0;
            r_res_from_mem <= 1'b0;
            r_rf_we        <= 1'b0;
            r_rf_waddr     <= '0;
            r_alu_result   <= '0;
        end else if (ms_flush) begin
            r_valid <= 1'b0;
        end else if (w_capture) begin
            r_valid        <= 1'b1;
            r_pc           <= es_pc;
            r_mem_req      <= es_mem_req;
            r_ld_op        <= es_ld_op;
            r_res_from_mem <= es_res_from_mem;
            r_rf_we        <= es_rf_we;
            r_rf_waddr     <= es_rf_waddr;
            r_alu_result   <= es_alu_result;
        end else if (w_ready_go & ws_allowin) begin
            r_valid <= 1'b0;
        end
    end

    // Response buffer: hold rdata until WB takes the instruction
    always_ff @(posedge clk) begin
        if (reset) begin
            r_got       <= 1'b0;
            r_rdata_buf <= '0;
        end else if (w_capture) begin
            r_got <= 1'b0;
        end else if (w_waiting & w_deliver) begin
            r_got       <= 1'b1;
            r_rdata_buf <= data_sram_rdata;
        end
    end

    // Outstanding stale-response counter
    always_ff @(posedge clk) begin
        if (reset) begin
            r_discard_cnt <= '0;
        end else begin
            r_discard_cnt <= w_cnt_sum[CNT_W-1:0];
        end
    end

`ifndef SYNTHESIS
    // Overflowing the discard counter means EX ignored ms_discard_busy
    always_ff @(posedge clk) begin
        if (!reset && (w_cnt_sum > SUM_W'(MAX_OUTST))) begin
            $error("mem_stage_pipe: discard counter exceeds MAX_OUTST");
        end
    end
`endif

endmodule

// File: tb/tb_mem_stage_pipe.sv
// tb_mem_stage_pipe: directed vectors for mem_stage_pipe (32-bit and 64-bit instances).
module tb_mem_stage_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    logic        es2ms_valid, ms_allowin, es_mem_req, es_res_from_mem, es_rf_we;
    logic        data_ok, ms_flush, ms_discard_busy, ms2ws_valid, ws_allowin;
    logic [31:0] es_pc, ms_pc, es_alu_result, rdata;
    logic [2:0]  es_ld_op;
    logic [4:0]  es_rf_waddr;
    logic [37:0] ms_rf_zip;

    logic        v64, allowin64, memreq64, res64, we64, dok64, flush64, busy64, msv64, wsa64;
    logic [31:0] pc64_in, pc64_out;
    logic [63:0] alu64, rdata64;
    logic [2:0]  op64;
    logic [4:0]  wa64;
    logic [69:0] zip64;

    mem_stage_pipe u_dut (
        .clk               (clk),
        .reset             (reset),
        .es2ms_valid       (es2ms_valid),
        .ms_allowin        (ms_allowin),
        .es_pc             (es_pc),
        .es_mem_req        (es_mem_req),
        .es_ld_op          (es_ld_op),
        .es_res_from_mem   (es_res_from_mem),
        .es_rf_we          (es_rf_we),
        .es_rf_waddr       (es_rf_waddr),
        .es_alu_result     (es_alu_result),
        .data_sram_data_ok (data_ok),
        .data_sram_rdata   (rdata),
        .ms_flush          (ms_flush),
        .ms_discard_busy   (ms_discard_busy),
        .ms2ws_valid       (ms2ws_valid),
        .ws_allowin        (ws_allowin),
        .ms_pc             (ms_pc),
        .ms_rf_zip         (ms_rf_zip)
    );

    mem_stage_pipe #(.DATA_W(64)) u_dut64 (
        .clk               (clk),
        .reset             (reset),
        .es2ms_valid       (v64),
        .ms_allowin        (allowin64),
        .es_pc             (pc64_in),
        .es_mem_req        (memreq64),
        .es_ld_op          (op64),
        .es_res_from_mem   (res64),
        .es_rf_we          (we64),
        .es_rf_waddr       (wa64),
        .es_alu_result     (alu64),
        .data_sram_data_ok (dok64),
        .data_sram_rdata   (rdata64),
        .ms_flush          (flush64),
        .ms_discard_busy   (busy64),
        .ms2ws_valid       (msv64),
        .ws_allowin        (wsa64),
        .ms_pc             (pc64_out),
        .ms_rf_zip         (zip64)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        mem;
        logic        res;
        logic [2:0]  op;
        logic [31:0] alu;
        logic [31:0] rd;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[9];

    task automatic load64(input string name, input logic [2:0] op, input logic [63:0] addr,
                          input logic [63:0] rd, input logic [63:0] exp);
        v64 = 1'b1; memreq64 = 1'b1; res64 = 1'b1; we64 = 1'b1; wa64 = 5'd7;
        op64 = op; alu64 = addr;
        step();
        v64 = 1'b0;
        dok64 = 1'b1; rdata64 = rd;
        #1;
        chk({name, "_valid"}, 128'(msv64), 128'(1'b1));
        chk(name, 128'(zip64), 128'({1'b1, 5'd7, exp}));
        step();
        dok64 = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //           mem   res   op    alu            rdata          we    wa     expected
        vecs[0] = '{1'b0, 1'b0, 3'd0, 32'h0000_1234, 32'h0,        1'b1, 5'd3,  32'h0000_1234};
        vecs[1] = '{1'b1, 1'b1, 3'd1, 32'h0000_1001, 32'h0000_8000, 1'b1, 5'd5,  32'hFFFF_FF80};
        vecs[2] = '{1'b1, 1'b1, 3'd2, 32'h0000_1001, 32'h0000_8000, 1'b1, 5'd6,  32'h0000_0080};
        vecs[3] = '{1'b1, 1'b1, 3'd4, 32'h0000_1002, 32'hBEEF_0000, 1'b1, 5'd7,  32'h0000_BEEF};
        vecs[4] = '{1'b1, 1'b1, 3'd3, 32'h0000_0002, 32'h8001_0000, 1'b1, 5'd8,  32'hFFFF_8001};
        vecs[5] = '{1'b1, 1'b1, 3'd0, 32'h0000_0100, 32'hDEAD_BEEF, 1'b1, 5'd9,  32'hDEAD_BEEF};
        vecs[6] = '{1'b1, 1'b1, 3'd1, 32'h0000_0003, 32'h7F00_0000, 1'b1, 5'd10, 32'h0000_007F};
        vecs[7] = '{1'b1, 1'b0, 3'd0, 32'h0000_2000, 32'h1234_5678, 1'b0, 5'd11, 32'h0000_2000};
        vecs[8] = '{1'b1, 1'b1, 3'd2, 32'h0000_0000, 32'h0000_00FF, 1'b1, 5'd12, 32'h0000_00FF};

        reset = 1'b1;
        es2ms_valid = 0; es_mem_req = 0; es_res_from_mem = 0; es_rf_we = 0; es_ld_op = 0;
        es_rf_waddr = 0; es_alu_result = 0; es_pc = 0; data_ok = 0; rdata = 0;
        ms_flush = 0; ws_allowin = 1;
        v64 = 0; memreq64 = 0; res64 = 0; we64 = 0; op64 = 0; wa64 = 0; alu64 = 0;
        pc64_in = 0; dok64 = 0; rdata64 = 0; flush64 = 0; wsa64 = 1;
        repeat (2) step();
        reset = 1'b0;
        #1;
        chk("rst_valid", 128'(ms2ws_valid), 128'(1'b0));
        chk("rst_zip", 128'(ms_rf_zip), 128'(38'h0));
        chk("rst_pc", 128'(ms_pc), 128'(32'h0));
        chk("rst_allowin", 128'(ms_allowin), 128'(1'b1));
        chk("rst_busy", 128'(ms_discard_busy), 128'(1'b0));

        // Table: ALU ops, loads of each width/extension, a store
        for (int i = 0; i < 9; i++) begin
            es2ms_valid = 1'b1; es_mem_req = vecs[i].mem; es_res_from_mem = vecs[i].res;
            es_ld_op = vecs[i].op; es_alu_result = vecs[i].alu; es_rf_we = vecs[i].we;
            es_rf_waddr = vecs[i].wa; es_pc = 32'h1000 + 32'(i) * 4;
            #1;
            chk($sformatf("v%0d_allowin_in", i), 128'(ms_allowin), 128'(1'b1));
            step();
            es2ms_valid = 1'b0;
            #1;
            chk($sformatf("v%0d_pc", i), 128'(ms_pc), 128'(32'h1000 + 32'(i) * 4));
            if (vecs[i].mem) begin
                chk($sformatf("v%0d_wait_valid", i), 128'(ms2ws_valid), 128'(1'b0));
                chk($sformatf("v%0d_wait_allowin", i), 128'(ms_allowin), 128'(1'b0));
                data_ok = 1'b1; rdata = vecs[i].rd;
                #1;
            end
            chk($sformatf("v%0d_valid", i), 128'(ms2ws_valid), 128'(1'b1));
            chk($sformatf("v%0d_zip", i), 128'(ms_rf_zip),
                128'({vecs[i].we, vecs[i].wa, vecs[i].exp}));
            step();
            data_ok = 1'b0;
            #1;
            chk($sformatf("v%0d_drained", i), 128'(ms2ws_valid), 128'(1'b0));
        end

        // WB stall: response buffered while rdata bus changes
        es2ms_valid = 1; es_mem_req = 1; es_res_from_mem = 1; es_ld_op = 3'd0;
        es_rf_we = 1; es_rf_waddr = 5'd13; es_alu_result = 32'h40;
        step();
        es2ms_valid = 0; ws_allowin = 0; data_ok = 1; rdata = 32'h1122_3344;
        #1;
        chk("buf_dok_valid", 128'(ms2ws_valid), 128'(1'b1));
        chk("buf_dok_allowin", 128'(ms_allowin), 128'(1'b0));
        step();
        data_ok = 0; rdata = 32'hFFFF_FFFF;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("buf_hold%0d_zip", c), 128'(ms_rf_zip),
                128'({1'b1, 5'd13, 32'h1122_3344}));
            chk($sformatf("buf_hold%0d_allowin", c), 128'(ms_allowin), 128'(1'b0));
            if (c < 2) step();
        end
        ws_allowin = 1;
        #1;
        chk("buf_release_valid", 128'(ms2ws_valid), 128'(1'b1));
        chk("buf_release_allowin", 128'(ms_allowin), 128'(1'b1));
        chk("buf_release_zip", 128'(ms_rf_zip), 128'({1'b1, 5'd13, 32'h1122_3344}));
        step();
        chk("buf_drained", 128'(ms2ws_valid), 128'(1'b0));

        // Flush during WAIT with a new EX request: two responses discarded
        es2ms_valid = 1; es_mem_req = 1; es_alu_result = 32'h300; es_rf_waddr = 5'd4;
        step();
        ms_flush = 1; es_alu_result = 32'h304; es_rf_waddr = 5'd14;
        #1;
        chk("fl_valid", 128'(ms2ws_valid), 128'(1'b0));
        chk("fl_busy_before", 128'(ms_discard_busy), 128'(1'b0));
        step();
        ms_flush = 0; es2ms_valid = 0; es_mem_req = 0;
        #1;
        chk("fl_busy2", 128'(ms_discard_busy), 128'(1'b1));
        chk("fl_allowin", 128'(ms_allowin), 128'(1'b1));
        data_ok = 1; rdata = 32'hAAAA_AAAA;
        #1;
        chk("fl_drop1_valid", 128'(ms2ws_valid), 128'(1'b0));
        step();
        data_ok = 0;
        #1;
        chk("fl_busy1", 128'(ms_discard_busy), 128'(1'b1));
        data_ok = 1; rdata = 32'hBBBB_BBBB;
        #1;
        chk("fl_drop2_valid", 128'(ms2ws_valid), 128'(1'b0));
        step();
        data_ok = 0;
        #1;
        chk("fl_busy0", 128'(ms_discard_busy), 128'(1'b0));
        chk("fl_idle_valid", 128'(ms2ws_valid), 128'(1'b0));
        es2ms_valid = 1; es_mem_req = 0; es_res_from_mem = 0; es_alu_result = 32'h55;
        es_rf_we = 1; es_rf_waddr = 5'd2;
        step();
        es2ms_valid = 0;
        #1;
        chk("fl_after_zip", 128'(ms_rf_zip), 128'({1'b1, 5'd2, 32'h55}));
        step();

        // Reset mid-WAIT with a nonzero discard count
        es2ms_valid = 1; es_mem_req = 1; es_res_from_mem = 1; es_alu_result = 32'h80;
        step();
        es2ms_valid = 0; ms_flush = 1;
        step();
        ms_flush = 0;
        #1;
        chk("rw_busy", 128'(ms_discard_busy), 128'(1'b1));
        es2ms_valid = 1;
        step();
        es2ms_valid = 0; es_mem_req = 0;
        #1;
        chk("rw_wait_allowin", 128'(ms_allowin), 128'(1'b0));
        reset = 1;
        step();
        reset = 0;
        #1;
        chk("rw_valid", 128'(ms2ws_valid), 128'(1'b0));
        chk("rw_zip", 128'(ms_rf_zip), 128'(38'h0));
        chk("rw_pc", 128'(ms_pc), 128'(32'h0));
        chk("rw_allowin", 128'(ms_allowin), 128'(1'b1));
        chk("rw_busy0", 128'(ms_discard_busy), 128'(1'b0));

        // 64-bit datapath extraction
        load64("d64_ldw", 3'd0, 64'h4, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_8000_0000);
        load64("d64_ldwu", 3'd5, 64'h4, 64'h8000_0000_0000_0000, 64'h0000_0000_8000_0000);
        load64("d64_ldd", 3'd6, 64'h8, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF);
        load64("d64_ldh", 3'd3, 64'h6, 64'h8765_0000_0000_0000, 64'hFFFF_FFFF_FFFF_8765);
        load64("d64_ldbu", 3'd2, 64'h5, 64'h0000_AB00_0000_0000, 64'h0000_0000_0000_00AB);
        load64("d64_ldw_lo", 3'd0, 64'h0, 64'h8000_0000_7000_0001, 64'h0000_0000_7000_0001);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
